// File: rtl/spi_master_ctrl_if.sv
// Host and serial-bus signal bundle for spi_master_ctrl.
//   master modport : the controller's view (host requests and miso in; status, rx word, SPI lines out)
//   slave modport  : the view of whatever drives the controller (host logic plus the SPI slave)
// Signals:
//   start    request a transfer (taken only while busy=0)
//   tx_data  word to send            ss_sel  slave index
//   cpol     SCK idle level          cpha    0: sample on leading edge, 1: on trailing edge
//   busy     transfer in progress    done    one-cycle end-of-transfer pulse
//   rx_data  last received word
//   sck/mosi/miso/nss  SPI lines (nss active-low, one line per slave)
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 2
);
  localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [SS_W-1:0]   ss_sel;
  logic              cpol;
  logic              cpha;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sck;
  logic              mosi;
  logic              miso;
  logic [NUM_SS-1:0] nss;

  modport master (
    input  start, tx_data, ss_sel, cpol, cpha, miso,
    output busy, done, rx_data, sck, mosi, nss
  );

  modport slave (
    output start, tx_data, ss_sel, cpol, cpha, miso,
    input  busy, done, rx_data, sck, mosi, nss
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Parametrised SPI master. Divides clk down to SCK, asserts one of NUM_SS
// active-low selects, and shifts a DATA_W-bit word full-duplex in any of the
// four SPI modes (cpol/cpha latched per transfer), MSB- or LSB-first.
// Ports:
//   clk  system clock, all logic on posedge
//   rst  synchronous active-high reset
//   bus  spi_master_ctrl_if.master: start/tx_data/ss_sel/cpol/cpha/miso in,
//        busy/done/rx_data/sck/mosi/nss out (all outputs registered)
// Timing (accept at cycle T): LEAD for CLK_DIV cycles, SCK edge k lands at
// T+1+CLK_DIV*(k+1), TRAIL for CLK_DIV cycles, done at T+1+CLK_DIV*(2*DATA_W+1).
module spi_master_ctrl #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int NUM_SS    = 2,
  parameter int LSB_FIRST = 0
) (
  input logic               clk,
  input logic               rst,
  spi_master_ctrl_if.master bus
);

  localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGES  = 2 * DATA_W;
  localparam int EDGE_W = $clog2(EDGES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [EDGE_W-1:0]   edge_q, edge_n;
  logic                sck_q, sck_n;
  logic                mosi_q, mosi_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
  logic                cpol_q, cpol_n;
  logic                cpha_q, cpha_n;
  logic [NUM_SS-1:0]   nss_q, nss_n;
  logic [DATA_W-1:0]   rx_data_q, rx_data_n;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_n;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_n;

  // Bit that goes out next from a tx shift register.
  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  // First received bit ends up at the MSB (or LSB when LSB_FIRST) after DATA_W shifts.
  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b);
    return (LSB_FIRST != 0) ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // Out-of-range indices select nothing, so the transfer runs with all lines high.
  function automatic logic [NUM_SS-1:0] decode_nss(input logic [SS_W-1:0] sel);
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (int'(sel) == i) v[i] = 1'b0;
    end
    return v;
  endfunction

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    edge_n    = edge_q;
    sck_n     = sck_q;
    mosi_n    = mosi_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    cpol_n    = cpol_q;
    cpha_n    = cpha_q;
    nss_n     = nss_q;
    rx_data_n = rx_data_q;
    tx_sr_n   = tx_sr_q;
    rx_sr_n   = rx_sr_q;

    case (state_q)
      IDLE: begin
        sck_n  = cpol_q;
        busy_n = 1'b0;
        nss_n  = '1;
        if (bus.start) begin
          state_n = LEAD;
          cnt_n   = '0;
          edge_n  = '0;
          busy_n  = 1'b1;
          nss_n   = decode_nss(bus.ss_sel);
          cpol_n  = bus.cpol;
          cpha_n  = bus.cpha;
          sck_n   = bus.cpol;
          rx_sr_n = '0;
          // cpha=0 needs the first bit valid before the first (sampling) edge.
          if (!bus.cpha) begin
            mosi_n  = head_bit(bus.tx_data);
            tx_sr_n = tx_shift(bus.tx_data);
          end else begin
            tx_sr_n = bus.tx_data;
          end
        end
      end

      LEAD, XFER: begin
        cnt_n = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_n  = '0;
          sck_n  = ~sck_q;
          edge_n = edge_q + 1'b1;
          // Even edges are leading; the sampling edge is leading when cpha=0.
          if (edge_q[0] == cpha_q) begin
            rx_sr_n = rx_shift(rx_sr_q, bus.miso);
          end else if (cpha_q || (edge_q != EDGE_LAST)) begin
            mosi_n  = head_bit(tx_sr_q);
            tx_sr_n = tx_shift(tx_sr_q);
          end
          state_n = (edge_q == EDGE_LAST) ? TRAIL : XFER;
        end
      end

      TRAIL: begin
        cnt_n = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_n     = '0;
          state_n   = IDLE;
          nss_n     = '1;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          rx_data_n = rx_sr_q;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      edge_q    <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cpol_q    <= 1'b0;
      nss_q     <= '1;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      edge_q    <= edge_n;
      sck_q     <= sck_n;
      mosi_q    <= mosi_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      cpol_q    <= cpol_n;
      nss_q     <= nss_n;
      rx_data_q <= rx_data_n;
    end
  end

  // Shift registers and cpha are reloaded on every accept, so they carry no reset.
  always_ff @(posedge clk) begin
    tx_sr_q <= tx_sr_n;
    rx_sr_q <= rx_sr_n;
    cpha_q  <= cpha_n;
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.sck     = sck_q;
  assign bus.mosi    = mosi_q;
  assign bus.nss     = nss_q;

endmodule
